// File: rtl/decode_scan_reg_if.sv
// Handshake bundle for decode_scan_reg: select input side and decoded beat output side.
interface decode_scan_reg_if #(
    parameter int unsigned SEL_W = 2
);
    localparam int unsigned OUT_W = 2 ** SEL_W;

    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic             scan_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;
    logic             out_last;

    // Producer of selects and consumer of beats
    modport master (
        output in_valid, sel, scan_en, out_ready,
        input  in_ready, out_valid, out, out_last
    );

    // The decoder itself
    modport slave (
        input  in_valid, sel, scan_en, out_ready,
        output in_ready, out_valid, out, out_last
    );
endinterface

// File: rtl/decode_scan_reg.sv
// Registered N-to-2^N line decoder with valid/ready handshake.
// Direct mode emits one beat per accepted select; scan mode walks the active
// line from the accepted select up to the top line, one beat per consumer take.
module decode_scan_reg #(
    parameter int unsigned SEL_W      = 2,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    decode_scan_reg_if.slave  bus
);
    localparam int unsigned      OUT_W    = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] SEL_TOP  = {SEL_W{1'b1}};
    localparam logic [OUT_W-1:0] OUT_IDLE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]       r_state;
    logic [SEL_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_out;
    logic             r_last;
    logic             r_valid;

    logic [0:0]       w_state_nxt;
    logic [SEL_W-1:0] w_cnt_nxt;
    logic [OUT_W-1:0] w_out_nxt;
    logic             w_last_nxt;
    logic             w_valid_nxt;

    logic             w_in_ready;
    logic             w_acc;
    logic [SEL_W-1:0] w_cnt_inc;

    // One active line at position idx, polarity chosen by ACTIVE_LOW
    function automatic logic [OUT_W-1:0] f_decode(input logic [SEL_W-1:0] idx);
        logic [OUT_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return ACTIVE_LOW ? ~v : v;
    endfunction

    // Ready depends only on state and the output slot, never on in_valid
    assign w_in_ready = (r_state == ST_IDLE) & (~r_valid | bus.out_ready);
    assign w_acc      = bus.in_valid & w_in_ready;
    assign w_cnt_inc  = r_cnt + 1'b1;

    // Next-state: load on accept, advance scan on take, blank the output when it retires
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_last_nxt  = r_last;
        w_valid_nxt = r_valid;
        if (r_state == ST_IDLE) begin
            if (w_acc) begin
                w_cnt_nxt   = bus.sel;
                w_out_nxt   = f_decode(bus.sel);
                w_valid_nxt = 1'b1;
                if (!bus.scan_en || (bus.sel == SEL_TOP)) begin
                    w_last_nxt = 1'b1;
                end else begin
                    w_last_nxt  = 1'b0;
                    w_state_nxt = ST_SCAN;
                end
            end else if (bus.out_ready) begin
                // Retire without replacement: never leave a stale line visible
                w_valid_nxt = 1'b0;
                w_out_nxt   = OUT_IDLE;
                w_last_nxt  = 1'b0;
            end
        end else begin
            if (bus.out_ready) begin
                w_cnt_nxt   = w_cnt_inc;
                w_out_nxt   = f_decode(w_cnt_inc);
                w_valid_nxt = 1'b1;
                w_last_nxt  = (w_cnt_inc == SEL_TOP);
                if (w_cnt_inc == SEL_TOP) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        end
    end

    // State and output registers; async reset abandons any burst in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= OUT_IDLE;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_last  <= w_last_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out       = r_out;
    assign bus.out_last  = r_last;
endmodule

// File: tb/tb_decode_scan_reg.sv
// Self-checking bench for decode_scan_reg: directed scenarios plus randomized
// traffic checked against a queue-of-beats reference model.
module tb_decode_scan_reg;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int idx;
        bit last;
    } beat_t;

    decode_scan_reg_if #(.SEL_W(2)) bus4 ();
    decode_scan_reg_if #(.SEL_W(3)) bus8 ();

    decode_scan_reg #(.SEL_W(2), .ACTIVE_LOW(1'b1)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    decode_scan_reg #(.SEL_W(3), .ACTIVE_LOW(1'b0)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus4.in_valid  = 1'b0;
        bus4.sel       = '0;
        bus4.scan_en   = 1'b0;
        bus4.out_ready = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.sel       = '0;
        bus8.scan_en   = 1'b0;
        bus8.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
        // Park a valid beat in the output register, then reset mid-cycle
        bus4.in_valid  = 1'b1;
        bus4.sel       = 2'd2;
        bus4.out_ready = 1'b0;
        tick();
        bus4.in_valid = 1'b0;
        checks++;
        if (bus4.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_preload_valid: got %b expected 1", bus4.out_valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus4.out !== 4'b1111) begin
            errors++;
            $display("FAIL reset_out: got %b expected 1111", bus4.out);
        end
        checks++;
        if (bus4.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", bus4.out_valid);
        end
        checks++;
        if (bus4.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", bus4.in_ready);
        end
        checks++;
        if (bus4.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_last: got %b expected 0", bus4.out_last);
        end
        #1;
        rst_n = 1'b1;
        bus4.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_direct();
        logic [3:0] tbl [4];
        tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            bus4.in_valid = 1'b1;
            bus4.sel      = 2'(i);
            #1;
            checks++;
            if (bus4.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL direct_in_ready[%0d]: got %b expected 1", i, bus4.in_ready);
            end
            tick();
            checks++;
            if (bus4.out !== tbl[i] || bus4.out_valid !== 1'b1 || bus4.out_last !== 1'b1) begin
                errors++;
                $display("FAIL direct_beat[%0d]: got out=%b v=%b l=%b expected out=%b v=1 l=1",
                         i, bus4.out, bus4.out_valid, bus4.out_last, tbl[i]);
            end
        end
        bus4.in_valid = 1'b0;
        tick();
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.out !== 4'b1111) begin
            errors++;
            $display("FAIL direct_drain: got out=%b v=%b expected out=1111 v=0",
                     bus4.out, bus4.out_valid);
        end
    endtask

    task automatic test_scan();
        logic [3:0] tbl [3];
        logic       lst [3];
        tbl = '{4'b1101, 4'b1011, 4'b0111};
        lst = '{1'b0, 1'b0, 1'b1};
        idle_inputs();
        bus4.in_valid = 1'b1;
        bus4.sel      = 2'd1;
        bus4.scan_en  = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        bus4.scan_en  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus4.out !== tbl[i] || bus4.out_last !== lst[i] || bus4.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL scan_beat[%0d]: got out=%b l=%b v=%b expected out=%b l=%b v=1",
                         i, bus4.out, bus4.out_last, bus4.out_valid, tbl[i], lst[i]);
            end
            checks++;
            if (bus4.in_ready !== (i == 2)) begin
                errors++;
                $display("FAIL scan_in_ready[%0d]: got %b expected %b", i, bus4.in_ready, i == 2);
            end
            tick();
        end
        checks++;
        if (bus4.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL scan_end_valid: got %b expected 0", bus4.out_valid);
        end
    endtask

    task automatic test_scan_stall();
        logic pat [4];
        int   idx;
        int   cyc;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        idle_inputs();
        bus4.in_valid = 1'b1;
        bus4.sel      = 2'd0;
        bus4.scan_en  = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 24) begin
            bus4.out_ready = pat[cyc % 4];
            #1;
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.out !== 4'(15 - (1 << idx))
                || bus4.out_last !== (idx == 3)) begin
                errors++;
                $display("FAIL stall_beat[%0d] cyc %0d: got out=%b v=%b l=%b expected out=%b v=1 l=%b",
                         idx, cyc, bus4.out, bus4.out_valid, bus4.out_last,
                         4'(15 - (1 << idx)), idx == 3);
            end
            if (bus4.out_ready) idx++;
            tick();
            cyc++;
        end
        checks++;
        if (idx != 4) begin
            errors++;
            $display("FAIL stall_beat_count: got %0d expected 4", idx);
        end
        bus4.out_ready = 1'b1;
        #1;
        checks++;
        if (bus4.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_no_extra_beat: got %b expected 0", bus4.out_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        idle_inputs();
        bus4.in_valid = 1'b1;
        bus4.sel      = 2'd0;
        bus4.scan_en  = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        tick();
        checks++;
        if (bus4.out !== 4'b1101) begin
            errors++;
            $display("FAIL midburst_second_beat: got %b expected 1101", bus4.out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus4.out !== 4'b1111 || bus4.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midburst_reset: got out=%b v=%b expected out=1111 v=0",
                     bus4.out, bus4.out_valid);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus4.out_valid !== 1'b0 || bus4.out !== 4'b1111) begin
                errors++;
                $display("FAIL midburst_post_release[%0d]: got out=%b v=%b expected out=1111 v=0",
                         i, bus4.out, bus4.out_valid);
            end
        end
        bus4.in_valid = 1'b1;
        bus4.sel      = 2'd2;
        bus4.scan_en  = 1'b0;
        tick();
        bus4.in_valid = 1'b0;
        checks++;
        if (bus4.out !== 4'b1011 || bus4.out_last !== 1'b1 || bus4.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midburst_direct: got out=%b v=%b l=%b expected out=1011 v=1 l=1",
                     bus4.out, bus4.out_valid, bus4.out_last);
        end
        tick();
    endtask

    task automatic test_wide_active_high();
        idle_inputs();
        bus8.in_valid = 1'b1;
        bus8.sel      = 3'd5;
        bus8.scan_en  = 1'b0;
        tick();
        bus8.in_valid = 1'b0;
        checks++;
        if (bus8.out !== 8'b0010_0000 || bus8.out_last !== 1'b1 || bus8.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wide_direct: got out=%b v=%b l=%b expected out=00100000 v=1 l=1",
                     bus8.out, bus8.out_valid, bus8.out_last);
        end
        tick();
        checks++;
        if (bus8.out !== 8'b0000_0000 || bus8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wide_idle: got out=%b v=%b expected out=00000000 v=0",
                     bus8.out, bus8.out_valid);
        end
        bus8.in_valid = 1'b1;
        bus8.sel      = 3'd7;
        bus8.scan_en  = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        bus8.scan_en  = 1'b0;
        #1;
        checks++;
        if (bus8.out !== 8'b1000_0000 || bus8.out_last !== 1'b1 || bus8.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wide_scan_top: got out=%b v=%b l=%b expected out=10000000 v=1 l=1",
                     bus8.out, bus8.out_valid, bus8.out_last);
        end
        // Staying idle means the next select is takeable while this beat retires
        checks++;
        if (bus8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wide_scan_top_ready: got %b expected 1", bus8.in_ready);
        end
        tick();
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wide_scan_top_single: got %b expected 0", bus8.out_valid);
        end
    endtask

    task automatic test_random();
        beat_t      q[$];
        beat_t      b;
        logic [3:0] exp_out;
        logic       exp_last;
        logic       exp_valid;
        logic       exp_rdy;
        int         s;
        idle_inputs();
        tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            exp_valid = (q.size() > 0);
            exp_out   = exp_valid ? 4'(15 - (1 << q[0].idx)) : 4'hF;
            exp_last  = exp_valid ? q[0].last : 1'b0;
            checks++;
            if (bus4.out_valid !== exp_valid) begin
                errors++;
                $display("FAIL rand_valid cyc %0d: got %b expected %b", cyc, bus4.out_valid, exp_valid);
            end
            checks++;
            if (bus4.out !== exp_out) begin
                errors++;
                $display("FAIL rand_out cyc %0d: got %b expected %b", cyc, bus4.out, exp_out);
            end
            checks++;
            if (bus4.out_last !== exp_last) begin
                errors++;
                $display("FAIL rand_last cyc %0d: got %b expected %b", cyc, bus4.out_last, exp_last);
            end
            bus4.out_ready = ($urandom_range(0, 9) < 7);
            bus4.in_valid  = 1'($urandom_range(0, 1));
            bus4.sel       = 2'($urandom_range(0, 3));
            bus4.scan_en   = 1'($urandom_range(0, 1));
            #1;
            // Busy while later beats of a burst are still unshown
            exp_rdy = (q.size() == 0) || (q.size() == 1 && bus4.out_ready);
            checks++;
            if (bus4.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_in_ready cyc %0d: got %b expected %b", cyc, bus4.in_ready, exp_rdy);
            end
            if (exp_valid && bus4.out_ready) void'(q.pop_front());
            if (bus4.in_valid && exp_rdy) begin
                s = int'(bus4.sel);
                if (bus4.scan_en) begin
                    for (int k = s; k < 4; k++) begin
                        b.idx  = k;
                        b.last = (k == 3);
                        q.push_back(b);
                    end
                end else begin
                    b.idx  = s;
                    b.last = 1'b1;
                    q.push_back(b);
                end
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_direct();
        test_scan();
        test_scan_stall();
        test_reset_mid_burst();
        test_wide_active_high();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
